insn_fetch_queue: RTL and testbench
===================================

# insn_fetch_queue

Instruction fetch front end placed between a handshaked instruction memory and the IF/ID pipeline register of the five-stage core. It generates sequential fetch addresses and issues requests with credit-based flow control. Returned instructions are buffered, each with its PC, in a small FIFO. On a taken branch or jump redirect, the FIFO is flushed and stale in-flight responses are discarded, so decode receives only correct-path `{pc, instr}` pairs under a valid/ready handshake.

## Interface
- `PC_W`, 9, byte-address width of the PC and of imem addresses
- `INS_W`, 32, instruction width
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `clock` in 1, clock
- `reset` in 1, reset, asynchronous, active-high
- `redirect_valid` in 1, taken branch/jump resolved in EX (BrFlush)
- `redirect_pc` in PC_W, new fetch target
- `imem_req_valid` out 1, fetch request valid
- `imem_req_addr` out PC_W, fetch byte address
- `imem_req_ready` in 1, memory accepts request
- `imem_rsp_valid` in 1, response valid; in request order, ≥1 cycle after acceptance
- `imem_rsp_data` in INS_W, returned instruction
- `if_valid` out 1, head entry valid
- `if_pc` out PC_W, PC of head entry
- `if_instr` out INS_W, instruction of head entry
- `if_ready` in 1, decode accepts head (= !stall)
- `occupancy` out $clog2(DEPTH)+1, FIFO entry count

## Operation
- **Reset state:** `fetch_pc` = 0, `rsp_pc` = 0, FIFO empty, `outstanding` = 0, `drop_cnt` = 0. Outputs: `imem_req_valid` = 0, `imem_req_addr` = 0, `if_valid` = 0, `if_pc` = 0, `if_instr` = 0, `occupancy` = 0.
- **Request issue:**
  - `imem_req_valid` = !`redirect_valid` && (`occupancy` + `outstanding` < `DEPTH`).
  - `imem_req_addr` = `fetch_pc`.
  - On an accepted request (valid && ready): `fetch_pc` += 4, modulo 2^PC_W, and `outstanding` += 1.
- **Response handling:**
  - Every `imem_rsp_valid` decrements `outstanding`.
  - If `drop_cnt` > 0, the response is discarded and `drop_cnt` −= 1.
  - Otherwise `{rsp_pc, imem_rsp_data}` is pushed and `rsp_pc` += 4 (same wrap).
  - The credit rule guarantees the FIFO cannot overflow.
  - A response arriving while `outstanding` = 0 is a protocol violation: it is ignored, and the bench asserts on it.
- **Pop:** the head is consumed when `if_valid` && `if_ready`. When empty, `if_pc` and `if_instr` read 0.
- **Redirect (cycle N):**
  - The FIFO is cleared.
  - `fetch_pc` and `rsp_pc` are set to `redirect_pc`.
  - `drop_cnt` is set to the outstanding requests still unanswered after this cycle's response, i.e. `outstanding` − `imem_rsp_valid`.
  - No request is issued in cycle N. A response arriving in cycle N is discarded.
- **Priority:** redirect > response push > pop. A pop coinciding with a redirect is treated as consumed; decode is flushed by the core.
- **Push and pop in the same cycle:** `occupancy` is unchanged.
- **Counter widths:** `outstanding` and `drop_cnt` are $clog2(DEPTH)+1 bits and never exceed `DEPTH`.

## Timing
- Request-to-FIFO path: response accepted in cycle R → `if_valid` with that entry in R+1. FIFO outputs are registered; there is no bypass.
- With a 1-cycle memory and `if_ready` = 1: request in C, response in C+1, decode sees the entry in C+2. After that, throughput is one instruction per cycle.
- Redirect in N:
  - `imem_req_valid` = 1 with `imem_req_addr` = `redirect_pc` in N+1.
  - `if_valid` = 0 in N+1.
  - The first correct-path instruction appears no earlier than N+3.
- `if_ready` low holds the head stable; the queue keeps filling until `occupancy` + `outstanding` = `DEPTH`.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the environment's responsibility; memory is reset together with this block.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` struct `{logic [PC_W-1:0] pc; logic [INS_W-1:0] instr;}`
  - `localparam PC_STEP = 4`
  - default `DEPTH`
- Sub-module `fetch_fifo`: circular buffer of `fetch_entry_t` with `push`, `pop`, `clear`, `count`; wrap-around read and write pointers plus a count. The top level holds the PC registers, credit logic and drop logic.

## Test plan
- **Reset, 1-cycle memory, `if_ready` = 1:** requests 0x000, 0x004, 0x008; `if_pc` sequence 0x000, 0x004, 0x008 starting in cycle 2, one per cycle.
- **`if_ready` = 0 for 10 cycles:** `occupancy` saturates at 4; `imem_req_valid` = 0 once credits hit 0; head `if_pc` held at 0x000.
- **Redirect to 0x040 with 2 responses in flight (3-cycle memory):** both responses dropped; next `if_pc` = 0x040, then 0x044.
- **Redirect in the same cycle as a response and a pop:** that response is discarded, `occupancy` = 0 in N+1, and `imem_req_addr` = 0x040 in N+1.
- **PC wrap, PC_W = 9:** fetch from 0x1FC; next request address 0x000 and next `if_pc` 0x000.
- **`reset` pulse mid-stream with 3 entries queued:** all outputs 0 in the same cycle; fetch restarts at 0x000.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch queue.
// Revision    : 1.0
// ============================================================================
package fetch_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int PC_STEP     = 4;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular buffer of fetched {pc, instr} entries with clear.
// Revision    : 1.0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type ENTRY_T = fetch_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  ENTRY_T                 push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output ENTRY_T                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_addr_w = $clog2(DEPTH);

  ENTRY_T              r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;
  logic                w_do_pop;

  assign w_do_pop = pop && (r_count != '0);

  // Storage is not reset; the head is masked by the count instead.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      case ({push, w_do_pop})
        2'b10:   r_count <= r_count + (c_addr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_addr_w+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_valid = (r_count != '0);
  assign head       = head_valid ? r_mem[r_rd_ptr] : '0;
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/insn_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : insn_fetch_queue
// Description : Credit-limited sequential fetch with redirect flush and drop.
// Revision    : 1.0
// ============================================================================
module insn_fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_W  = FETCH_PC_W,
  parameter int INS_W = FETCH_INS_W,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  output logic [PC_W-1:0]        imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INS_W-1:0]       imem_rsp_data,
  output logic                   if_valid,
  output logic [PC_W-1:0]        if_pc,
  output logic [INS_W-1:0]       if_instr,
  input  logic                   if_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int                c_cnt_w   = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w:0]  c_depth   = (c_cnt_w+1)'(DEPTH);
  localparam logic [PC_W-1:0]   c_pc_step = PC_W'(PC_STEP);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_rsp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic [c_cnt_w:0]   w_credit_used;
  logic               w_rsp_live;
  logic               w_req_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_head_valid;
  entry_t             w_push_entry;
  entry_t             w_head;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_live    = imem_rsp_valid && (r_outstanding != '0);
  assign w_credit_used = {1'b0, occupancy} + {1'b0, r_outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (w_credit_used < c_depth);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_push         = w_rsp_live && !redirect_valid && (r_drop_cnt == '0);
  assign w_pop          = w_head_valid && if_ready;
  assign w_push_entry   = '{pc: r_rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= '0;
      r_rsp_pc      <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_live);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_drop_cnt <= r_outstanding - c_cnt_w'(w_rsp_live);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + c_pc_step;
        end
        if (w_rsp_live && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (redirect_valid),
    .push       (w_push),
    .push_data  (w_push_entry),
    .pop        (w_pop),
    .head_valid (w_head_valid),
    .head       (w_head),
    .count      (occupancy)
  );

  assign if_valid = w_head_valid;
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_insn_fetch_queue
// Description : Table vectors plus scoreboarded memory model for the fetch queue.
// Revision    : 1.0
// ============================================================================
module tb_insn_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              imem_req_valid;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_req_ready = 1'b0;
  logic              imem_rsp_valid = 1'b0;
  logic [INS_W-1:0]  imem_rsp_data = '0;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INS_W-1:0]  if_instr;
  logic              if_ready = 1'b0;
  logic [2:0]        occupancy;

  insn_fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .occupancy      (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct { logic [PC_W-1:0] addr; int epoch; int due; } mem_req_t;
  typedef struct { logic [PC_W-1:0] pc; logic [INS_W-1:0] instr; } exp_t;
  typedef struct {
    logic            if_rdy;
    logic            req_v;
    logic [PC_W-1:0] req_a;
    logic            if_v;
    logic [PC_W-1:0] pc;
    logic [2:0]      occ;
  } vec_t;

  mem_req_t        mem_q[$];
  exp_t            sb[$];
  vec_t            tbl[6];
  int              cyc, epoch, mem_lat, n_checks, n_pass;
  logic            drv_ready, drv_if_ready, drv_redirect;
  logic [PC_W-1:0] drv_redirect_pc;

  function automatic logic [INS_W-1:0] mem_data(input logic [PC_W-1:0] a);
    return 32'h5A00_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive inputs at the falling edge, then sample and update models.
  task automatic cycle();
    mem_req_t r;
    exp_t     e;
    logic     rsp_keep;
    @(negedge clock);
    imem_req_ready = drv_ready;
    if_ready       = drv_if_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_keep       = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(r.addr);
      rsp_keep = !drv_redirect && (r.epoch == epoch);
    end
    #1;
    if (if_valid && if_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got pc 0x%0h, expected no entry (cycle %0d)", if_pc, cyc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", 32'(if_pc), 32'(e.pc));
        check("pop_instr", if_instr, e.instr);
      end
    end
    if (rsp_keep) sb.push_back('{pc: r.addr, instr: mem_data(r.addr)});
    if (imem_req_valid && imem_req_ready)
      mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + mem_lat});
    if (drv_redirect) begin
      sb.delete();
      epoch++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    drv_redirect = 1'b0;
    mem_q.delete();
    sb.delete();
    epoch = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cyc = 0;
  endtask

  task automatic drain(input string tag);
    drv_ready    = 1'b0;
    drv_if_ready = 1'b1;
    drv_redirect = 1'b0;
    for (int i = 0; i < 30 && (mem_q.size() > 0 || sb.size() > 0 || if_valid); i++) cycle();
    check({tag, "_drain_occ"}, 32'(occupancy), 32'd0);
    check({tag, "_drain_left"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; epoch = 0; mem_lat = 1;
    drv_ready = 1'b1; drv_if_ready = 1'b1; drv_redirect = 1'b0; drv_redirect_pc = '0;

    tbl[0] = '{1'b1, 1'b1, 9'h000, 1'b0, 9'h000, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 9'h004, 1'b0, 9'h000, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 9'h008, 1'b1, 9'h000, 3'd1};
    tbl[3] = '{1'b1, 1'b1, 9'h00C, 1'b1, 9'h004, 3'd1};
    tbl[4] = '{1'b1, 1'b1, 9'h010, 1'b1, 9'h008, 3'd1};
    tbl[5] = '{1'b1, 1'b1, 9'h014, 1'b1, 9'h00C, 3'd1};

    // Reset values
    @(posedge clock); #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", 32'(imem_req_addr), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_if_pc", 32'(if_pc), 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_occ", 32'(occupancy), 0);

    // Streaming with a 1-cycle memory
    do_reset();
    mem_lat = 1; drv_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drv_if_ready = tbl[i].if_rdy;
      cycle();
      check("vec_req_valid", 32'(imem_req_valid), 32'(tbl[i].req_v));
      check("vec_req_addr", 32'(imem_req_addr), 32'(tbl[i].req_a));
      check("vec_if_valid", 32'(if_valid), 32'(tbl[i].if_v));
      check("vec_if_pc", 32'(if_pc), 32'(tbl[i].pc));
      check("vec_occ", 32'(occupancy), 32'(tbl[i].occ));
    end
    drain("stream");

    // Decode stalled: queue fills to the credit limit
    do_reset();
    mem_lat = 1; drv_ready = 1'b1; drv_if_ready = 1'b0;
    repeat (10) cycle();
    check("stall_occ", 32'(occupancy), 32'(DEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 0);
    check("stall_if_valid", 32'(if_valid), 1);
    check("stall_if_pc", 32'(if_pc), 32'h000);
    drain("stall");

    // Redirect with two responses in flight, 3-cycle memory
    do_reset();
    mem_lat = 3; drv_ready = 1'b1; drv_if_ready = 1'b1;
    repeat (2) cycle();
    drv_redirect = 1'b1; drv_redirect_pc = 9'h040;
    cycle();
    check("redir_req_blocked", 32'(imem_req_valid), 0);
    drv_redirect = 1'b0;
    cycle();
    check("redir_req_valid", 32'(imem_req_valid), 1);
    check("redir_req_addr", 32'(imem_req_addr), 32'h040);
    check("redir_if_valid", 32'(if_valid), 0);
    repeat (8) cycle();
    drain("redir");

    // Redirect coinciding with a response and a pop
    do_reset();
    mem_lat = 1; drv_ready = 1'b1; drv_if_ready = 1'b1;
    repeat (2) cycle();
    drv_redirect = 1'b1; drv_redirect_pc = 9'h040;
    cycle();
    check("coinc_rsp_present", 32'(imem_rsp_valid), 1);
    check("coinc_pop_valid", 32'(if_valid), 1);
    check("coinc_req_blocked", 32'(imem_req_valid), 0);
    drv_redirect = 1'b0;
    cycle();
    check("coinc_occ", 32'(occupancy), 0);
    check("coinc_req_addr", 32'(imem_req_addr), 32'h040);
    check("coinc_req_valid", 32'(imem_req_valid), 1);
    check("coinc_if_valid", 32'(if_valid), 0);
    repeat (4) cycle();
    drain("coinc");

    // PC wrap at the top of the 9-bit space
    do_reset();
    mem_lat = 1; drv_ready = 1'b1; drv_if_ready = 1'b1;
    drv_redirect = 1'b1; drv_redirect_pc = 9'h1FC;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    check("wrap_req_addr0", 32'(imem_req_addr), 32'h1FC);
    cycle();
    check("wrap_req_addr1", 32'(imem_req_addr), 32'h000);
    cycle();
    check("wrap_if_pc0", 32'(if_pc), 32'h1FC);
    cycle();
    check("wrap_if_pc1", 32'(if_pc), 32'h000);
    drain("wrap");

    // Asynchronous reset with three entries queued
    do_reset();
    mem_lat = 1; drv_ready = 1'b1; drv_if_ready = 1'b0;
    repeat (5) cycle();
    check("mid_occ_before", 32'(occupancy), 3);
    reset = 1'b1;
    #1;
    check("mid_req_valid", 32'(imem_req_valid), 0);
    check("mid_req_addr", 32'(imem_req_addr), 0);
    check("mid_if_valid", 32'(if_valid), 0);
    check("mid_if_pc", 32'(if_pc), 0);
    check("mid_if_instr", if_instr, 0);
    check("mid_occ", 32'(occupancy), 0);
    do_reset();
    drv_if_ready = 1'b1;
    cycle();
    check("mid_restart_valid", 32'(imem_req_valid), 1);
    check("mid_restart_addr", 32'(imem_req_addr), 32'h000);
    repeat (4) cycle();
    drain("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
